// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, port indices
// and the width of the access wait counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Wide enough for WAIT-1 with WAIT up to 15.
    localparam int WCNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: a lone request wins outright, and on a tie the
// port that was not served most recently wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    // Pick the winner from the request pair and the last-served port.
    always_comb begin
        o_grant_valid = |i_req;
        o_grant_idx   = PORT_CPU;
        if (i_req == 2'b11) begin
            o_grant_idx = ~i_last;
        end else if (i_req[1]) begin
            o_grant_idx = PORT_AUX;
        end
    end

endmodule

// File: rtl/mem_arbiter_multi.sv
// Two-port arbiter/sequencer for the unified memory port of the multicycle
// core. The winning request is latched, held on the memory bus for WAIT
// cycles, and completed with a one-cycle acknowledge to its port.
module mem_arbiter_multi
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAIT   = 2
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iReq0,
    input  logic                iReq1,
    input  logic                iWe0,
    input  logic                iWe1,
    input  logic [ADDR_W-1:0]   iAddr0,
    input  logic [ADDR_W-1:0]   iAddr1,
    input  logic [DATA_W-1:0]   iWData0,
    input  logic [DATA_W-1:0]   iWData1,
    input  logic [DATA_W/8-1:0] iBE0,
    input  logic [DATA_W/8-1:0] iBE1,
    output logic                oAck0,
    output logic                oAck1,
    output logic [DATA_W-1:0]   oRData,
    output logic [ADDR_W-1:0]   oMemAddr,
    output logic [DATA_W-1:0]   oMemWData,
    output logic [DATA_W/8-1:0] oMemBE,
    output logic                oMemRe,
    output logic                oMemWe,
    input  logic [DATA_W-1:0]   iMemRData,
    output logic                oBusy,
    output logic                oGrant
);

    localparam int BE_W = DATA_W / 8;

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic [WCNT_W-1:0]   r_cnt;
    logic                r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_gvalid;
    logic                w_gidx;
    logic                w_last_beat;

    rr_pick2 u_pick (
        .i_req         ({iReq1, iReq0}),
        .i_last        (r_last),
        .o_grant_valid (w_gvalid),
        .o_grant_idx   (w_gidx)
    );

    assign w_last_beat = (r_cnt == '0);

    // The memory bus is fed only from the holding registers, so requesters
    // may change their inputs freely once granted.
    assign oMemAddr  = r_addr;
    assign oMemWData = r_wdata;
    assign oMemBE    = r_be;
    assign oRData    = r_rdata;
    assign oGrant    = r_grant;

    // State register; reset aborts any transfer in flight without an ack.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and decoded strobes; the write strobe fires only on the
    // final access cycle so each write is a single pulse.
    always_comb begin
        w_next = r_state;
        oMemRe = 1'b0;
        oMemWe = 1'b0;
        oAck0  = 1'b0;
        oAck1  = 1'b0;
        oBusy  = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_gvalid) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                oMemRe = ~r_we;
                oMemWe = r_we & w_last_beat;
                if (w_last_beat) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                oAck0  = (r_grant == PORT_CPU);
                oAck1  = (r_grant == PORT_AUX);
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Grant latching, wait countdown, read capture and round-robin history.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_grant <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gvalid) begin
                        r_grant <= w_gidx;
                        r_we    <= w_gidx ? iWe1    : iWe0;
                        r_addr  <= w_gidx ? iAddr1  : iAddr0;
                        r_wdata <= w_gidx ? iWData1 : iWData0;
                        r_be    <= w_gidx ? iBE1    : iBE0;
                        r_cnt   <= WCNT_W'(WAIT - 1);
                    end
                end
                ST_ACCESS: begin
                    if (!w_last_beat) begin
                        r_cnt <= r_cnt - WCNT_W'(1);
                    end else if (!r_we) begin
                        r_rdata <= iMemRData;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_grant;
                    r_grant <= PORT_CPU;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_multi.sv
// Bench for mem_arbiter_multi: a WAIT=2 instance with a byte-addressable
// memory model behind it, and a WAIT=1 instance for back-to-back reads.
// Expected results come from a transaction-level model (ref_mem, served-port
// history, fixed latency arithmetic).
module tb_mem_arbiter_multi;

    localparam int WAIT = 2;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iReq0, iReq1, iWe0, iWe1;
    logic [31:0] iAddr0, iAddr1, iWData0, iWData1;
    logic [3:0]  iBE0, iBE1;
    logic        oAck0, oAck1, oMemRe, oMemWe, oBusy, oGrant;
    logic [31:0] oRData, oMemAddr, oMemWData, iMemRData;
    logic [3:0]  oMemBE;

    logic        w1Req0, w1Ack0, w1Ack1, w1MemRe, w1MemWe, w1Busy, w1Grant;
    logic [31:0] w1Addr0, w1RData, w1MemAddr, w1MemWData, w1MemRData;
    logic [3:0]  w1MemBE;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem     [0:1023];
    bit          written [0:1023];
    logic [31:0] ref_mem [0:1023];

    always #5 iCLK = ~iCLK;

    mem_arbiter_multi #(.ADDR_W(32), .DATA_W(32), .WAIT(WAIT)) u_dut (
        .iCLK(iCLK), .iRST(iRST),
        .iReq0(iReq0), .iReq1(iReq1), .iWe0(iWe0), .iWe1(iWe1),
        .iAddr0(iAddr0), .iAddr1(iAddr1), .iWData0(iWData0), .iWData1(iWData1),
        .iBE0(iBE0), .iBE1(iBE1), .oAck0(oAck0), .oAck1(oAck1), .oRData(oRData),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemBE(oMemBE),
        .oMemRe(oMemRe), .oMemWe(oMemWe), .iMemRData(iMemRData),
        .oBusy(oBusy), .oGrant(oGrant)
    );

    mem_arbiter_multi #(.ADDR_W(32), .DATA_W(32), .WAIT(1)) u_dut_w1 (
        .iCLK(iCLK), .iRST(iRST),
        .iReq0(w1Req0), .iReq1(1'b0), .iWe0(1'b0), .iWe1(1'b0),
        .iAddr0(w1Addr0), .iAddr1(32'h0), .iWData0(32'h0), .iWData1(32'h0),
        .iBE0(4'h0), .iBE1(4'h0), .oAck0(w1Ack0), .oAck1(w1Ack1), .oRData(w1RData),
        .oMemAddr(w1MemAddr), .oMemWData(w1MemWData), .oMemBE(w1MemBE),
        .oMemRe(w1MemRe), .oMemWe(w1MemWe), .iMemRData(w1MemRData),
        .oBusy(w1Busy), .oGrant(w1Grant)
    );

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 32'h40) return 32'hDEADBEEF;
        return (32'(idx) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] env_word(input int idx);
        return written[idx] ? mem[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] w1_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] rand_addr();
        return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    endfunction

    assign iMemRData  = env_word(int'(oMemAddr[11:2]));
    assign w1MemRData = w1_word(w1MemAddr);

    // Memory behind the WAIT=2 instance: byte-enabled write on the strobe.
    always @(posedge iCLK) begin
        if (oMemWe) begin
            mem[oMemAddr[11:2]]     <= merge(env_word(int'(oMemAddr[11:2])), oMemWData, oMemBE);
            written[oMemAddr[11:2]] <= 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            iReq0 = req; iWe0 = we; iAddr0 = a; iWData0 = d; iBE0 = be;
        end else begin
            iReq1 = req; iWe1 = we; iAddr1 = a; iWData1 = d; iBE1 = be;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(oBusy),  32'h0);
        chk({tag, "_grant"}, 32'(oGrant), 32'h0);
        chk({tag, "_ack"},   32'({oAck1, oAck0}), 32'h0);
        chk({tag, "_strb"},  32'({oMemWe, oMemRe}), 32'h0);
        chk({tag, "_addr"},  oMemAddr, 32'h0);
        chk({tag, "_wdata"}, oMemWData, 32'h0);
        chk({tag, "_be"},    32'(oMemBE), 32'h0);
        chk({tag, "_rdata"}, oRData, 32'h0);
    endtask

    // One isolated transfer from an idle arbiter; live inputs are scrambled
    // after the grant to show the transfer runs from latched values.
    task automatic xfer(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input string tag);
        int cyc  = 0;
        int re_n = 0;
        int we_n = 0;
        bit got  = 0;
        int idx  = int'(a[11:2]);
        set_port(p, 1'b1, we, a, d, be);
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_grant"}, 32'(oGrant), 32'(p));
                chk({tag, "_busy"}, 32'(oBusy), 32'h1);
                set_port(p, 1'b1, ~we, a ^ 32'h200, ~d, ~be);
            end
            if (oAck0 || oAck1) begin
                got = 1;
            end else begin
                chk({tag, "_addr"}, oMemAddr, a);
                if (oMemRe) re_n++;
                if (oMemWe) begin
                    we_n++;
                    chk({tag, "_wdata"}, oMemWData, d);
                    chk({tag, "_be"}, 32'(oMemBE), 32'(be));
                end
            end
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(WAIT + 1));
        chk({tag, "_ackport"}, 32'({oAck1, oAck0}), (p == 0) ? 32'h1 : 32'h2);
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (!we) begin
            chk({tag, "_rdata"}, oRData, ref_mem[idx]);
            chk({tag, "_re_cycles"}, 32'(re_n), 32'(WAIT));
            chk({tag, "_we_cycles"}, 32'(we_n), 32'h0);
        end else begin
            ref_mem[idx] = merge(ref_mem[idx], d, be);
            chk({tag, "_re_cycles"}, 32'(re_n), 32'h0);
            chk({tag, "_we_cycles"}, 32'(we_n), 32'h1);
        end
        tick();
        chk({tag, "_idle_busy"}, 32'(oBusy), 32'h0);
        chk({tag, "_idle_grant"}, 32'(oGrant), 32'h0);
        chk({tag, "_idle_ack"}, 32'({oAck1, oAck0}), 32'h0);
        if (we) chk({tag, "_memword"}, env_word(idx), ref_mem[idx]);
    endtask

    task automatic new_req(input int p, output logic pw, output logic [31:0] pa,
                           output logic [31:0] pd, output logic [3:0] pb);
        pw = 1'($urandom_range(0, 1));
        pa = rand_addr();
        pd = $urandom;
        pb = 4'($urandom_range(1, 15));
        set_port(p, 1'b1, pw, pa, pd, pb);
    endtask

    // Both ports saturate from reset; the model expects strict alternation
    // starting at port 0 and one completion every WAIT+2 cycles.
    task automatic contention(input int n);
        logic        pw [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        logic [3:0]  pb [2];
        int   cyc = 0, last_ack = 0, acks = 0, p, idx;
        logic last_m = 1'b1;
        iRST = 1'b0;
        for (int q = 0; q < 2; q++) new_req(q, pw[q], pa[q], pd[q], pb[q]);
        tick();
        tick();
        iRST = 1'b1;
        while (acks < n && cyc < 200) begin
            tick();
            cyc++;
            if (oAck0 || oAck1) begin
                chk("cont_dual_ack", 32'(oAck0 & oAck1), 32'h0);
                p = oAck1 ? 1 : 0;
                chk("cont_order", 32'(p), last_m ? 32'h0 : 32'h1);
                chk("cont_gap", 32'(cyc - last_ack), (acks == 0) ? 32'(WAIT + 1) : 32'(WAIT + 2));
                idx = int'(pa[p][11:2]);
                if (!pw[p]) begin
                    chk("cont_rdata", oRData, ref_mem[idx]);
                end else begin
                    ref_mem[idx] = merge(ref_mem[idx], pd[p], pb[p]);
                    chk("cont_memword", env_word(idx), ref_mem[idx]);
                end
                last_m   = 1'(p);
                acks++;
                last_ack = cyc;
                new_req(p, pw[p], pa[p], pd[p], pb[p]);
            end
        end
        chk("cont_count", 32'(acks), 32'(n));
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
    endtask

    initial begin
        int cyc, acks, last, re_n;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        iRST = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        w1Req0 = 1'b0;
        w1Addr0 = 32'h0;
        tick();
        tick();
        chk_all_zero("reset");
        iRST = 1'b1;
        tick();
        chk_all_zero("post_reset");

        xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, "read100");
        chk("read100_value", oRData, 32'hDEADBEEF);
        xfer(1, 1'b1, 32'h200, 32'h12345678, 4'b0011, "write200");
        xfer(0, 1'b0, 32'h200, 32'h0, 4'h0, "readback200");
        for (int k = 0; k < 10; k++) begin
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
                 $urandom, 4'($urandom_range(1, 15)), "rand");
        end

        contention(6);

        // Reset in the second access cycle of a port-0 read.
        a = rand_addr();
        set_port(0, 1'b1, 1'b0, a, 32'h0, 4'h0);
        tick();
        tick();
        chk("rst_pre_re", 32'(oMemRe), 32'h1);
        iRST = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        chk("rst_no_ack", 32'({oAck1, oAck0}), 32'h0);
        iRST = 1'b1;
        cyc = 0;
        while (!oAck0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rst_retry_lat", 32'(cyc), 32'(WAIT + 1));
        chk("rst_retry_rdata", oRData, ref_mem[a[11:2]]);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // WAIT=1 instance: back-to-back held port-0 reads.
        w1Addr0 = rand_addr();
        w1Req0  = 1'b1;
        cyc = 0; acks = 0; last = 0; re_n = 0;
        while (acks < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (w1Ack0) begin
                chk("w1_gap", 32'(cyc - last), (acks == 0) ? 32'h2 : 32'h3);
                chk("w1_rdata", w1RData, w1_word(w1Addr0));
                chk("w1_re_cycles", 32'(re_n), 32'h1);
                acks++;
                last = cyc;
                re_n = 0;
                w1Addr0 = rand_addr();
            end else if (w1MemRe) begin
                re_n++;
            end
        end
        chk("w1_count", 32'(acks), 32'h4);
        w1Req0 = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_multi.md
# mem_arbiter_multi

Two-port arbiter and sequencer for the single unified memory port behind the multicycle RISC-V core. Port 0 serves the CPU (fetch/load/store issued by the multicycle control FSM), port 1 serves a secondary master (DMA/debug loader). It grants round-robin, latches the winning request and drives the memory for a fixed number of wait cycles. It then returns read data with a one-cycle acknowledge, so the CPU control FSM stalls on `oAck0` instead of assuming single-cycle memory.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8`.
- `WAIT`, default 2: memory access cycles per transfer, legal range 1..15.

- `iCLK`: input, 1 bit. Single clock; all state changes on its rising edge.
- `iRST`: input, 1 bit. Reset, asynchronous and active-low.
- `iReq0`, `iReq1`: input, 1 bit. Request, held high until the matching ack.
- `iWe0`, `iWe1`: input, 1 bit. 1 = write, 0 = read.
- `iAddr0`, `iAddr1`: input, `ADDR_W` bits. Byte address.
- `iWData0`, `iWData1`: input, `DATA_W` bits. Write data.
- `iBE0`, `iBE1`: input, `DATA_W/8` bits. Byte enables.
- `oAck0`, `oAck1`: output, 1 bit. One-cycle completion pulse.
- `oRData`: output, `DATA_W` bits. Read data, shared by both ports; valid only while `oAck0` or `oAck1` is high.
- `oMemAddr`: output, `ADDR_W` bits. Address to memory.
- `oMemWData`: output, `DATA_W` bits. Write data to memory.
- `oMemBE`: output, `DATA_W/8` bits. Byte enables to memory.
- `oMemRe`: output, 1 bit. Read strobe.
- `oMemWe`: output, 1 bit. Write strobe.
- `iMemRData`: input, `DATA_W` bits. Memory read data, valid in the last access cycle.
- `oBusy`: output, 1 bit. High in any state other than IDLE.
- `oGrant`: output, 1 bit. Port currently owning the memory (0 or 1).

## Operation
- Reset (`iRST` = 0, asynchronous):
  - state goes to IDLE, `last` = 1, counter = 0, all latches 0.
  - all outputs are 0.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - Only one request: grant that port.
  - Both requests: grant `~last`, i.e. the port not served most recently.
  - On grant: latch `we`, `addr`, `wdata` and `be` into holding registers, set `oGrant`, load counter = `WAIT-1`, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - `oMemAddr`, `oMemBE` and `oMemWData` come from the holding registers, never from live port inputs.
  - `oMemRe` = `!we` for every ACCESS cycle.
  - `oMemWe` = `we` only in the final ACCESS cycle (counter = 0), so each write is exactly one strobe.
  - Counter ≠ 0: decrement.
  - Counter = 0: if read, capture `iMemRData` into the read-data register; go to DONE.
- DONE:
  - Assert `oAck[grant]` for exactly one cycle; `oRData` presents the read-data register.
  - For writes, `oRData` keeps its previous value and is don't-care.
  - Set `last` = grant, then go to IDLE.
- `oBusy` = (state ≠ IDLE). `oGrant` holds the granted port from grant until return to IDLE; it is 0 in IDLE.
- Port inputs are ignored outside IDLE. A request dropped mid-transfer still completes and still acks.
- A requester must drop `iReq` on the edge that ends its ack cycle, unless it is issuing a new request. A held `iReq` at the next IDLE is a new transfer.

## Timing
- Request sampled high in IDLE at edge t:
  - ACCESS occupies cycles t+1 .. t+`WAIT`.
  - Ack is high in cycle t+`WAIT`+1.
  - Back in IDLE at cycle t+`WAIT`+2.
- Maximum throughput is one transfer per `WAIT`+2 cycles.
- With both ports saturating, grants alternate strictly 0, 1, 0, 1, …
- Starvation bound: a held request is granted within one foreign transfer.
- First simultaneous request after reset goes to port 0, because `last` resets to 1.
- Reset asserted in ACCESS or DONE:
  - `oMemWe`, `oMemRe` and acks drop immediately (asynchronously).
  - No ack is issued for the aborted transfer.
  - After reset release, the transfer is re-arbitrated only if its requester still asserts `iReq`.
- With `WAIT` = 1, ACCESS lasts one cycle and `oMemWe` / `oMemRe` are asserted together with the sample of `iMemRData`.

## Structure
- Shared package `mem_arb_pkg`:
  - state encodings `ST_IDLE`, `ST_ACCESS`, `ST_DONE`;
  - port index constants `PORT_CPU` = 0 and `PORT_AUX` = 1;
  - counter width constant `WCNT_W` = 4.
- One sub-module, `rr_pick2`: combinational two-input round-robin picker taking `req[1:0]` and `last` and returning `grant_valid` and `grant_idx`. FSM, counter and holding registers stay in the top module.

## Test plan
- Read, `WAIT`=2: port 0 reads address `0x100`; memory model returns `0xDEADBEEF`. Expect:
  - `oMemRe` high for 2 cycles;
  - `oAck0` pulse 3 cycles after the request edge, with `oRData` = `0xDEADBEEF`;
  - `oAck1` stays 0.
- Write strobe: port 1 writes `0x12345678` to `0x200` with BE=`4'b0011`. Expect:
  - exactly one `oMemWe` cycle, with `oMemAddr` = `0x200` and `oMemBE` = `0011`;
  - memory model bytes updated accordingly;
  - `oAck1` pulses once.
- Contention: both ports request continuously for 6 transfers from reset. Expect grant order 0,1,0,1,0,1 and never two acks in the same cycle.
- Latching: port 0 changes `iAddr0` from `0x100` to `0x300` during ACCESS. Expect `oMemAddr` to stay `0x100` for the whole transfer.
- Reset mid-operation: assert `iRST`=0 in the second ACCESS cycle. Expect:
  - all outputs 0 within that cycle, no ack;
  - after release with `iReq0` still held, a fresh transfer that acks after `WAIT`+1 cycles.
- `WAIT`=1 build: back-to-back port-0 reads complete every 3 cycles.
